// File: rtl/tdm_deserializer.sv
// Receive side of a single-wire TDM link: assembles framed serial bits into
// N_CH parallel channel words, pulsing frame_valid on completion and frame_err on abort.
module tdm_deserializer #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                serial_valid,
    input  logic                serial_data,
    input  logic                frame_start,
    output logic [N_CH*W-1:0]   ch_data,
    output logic                frame_valid,
    output logic                frame_err
);

    localparam int unsigned TOT = N_CH * W;
    localparam int unsigned BW  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IW  = (TOT > 1) ? $clog2(TOT) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]     state, state_nxt;
    logic [BW-1:0]  bit_cnt, bit_nxt, cap_b;
    logic [CW-1:0]  ch_cnt, ch_nxt, cap_c;
    logic [TOT-1:0] asm_buf, buf_nxt, data_nxt;
    logic [IW-1:0]  idx;
    logic           capture, fv_nxt, fe_nxt;

    // Next-state: capture position comes from the counters, or restarts at
    // channel 0 MSB whenever a frame_start beat arrives.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        ch_nxt    = ch_cnt;
        buf_nxt   = asm_buf;
        data_nxt  = ch_data;
        fv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        capture   = 1'b0;
        cap_b     = '0;
        cap_c     = '0;
        idx       = '0;

        if (serial_valid) begin
            if (frame_start) begin
                capture = 1'b1;
                fe_nxt  = (state == RECV);
                buf_nxt = '0;
            end else if (state == RECV) begin
                capture = 1'b1;
                cap_b   = bit_cnt;
                cap_c   = ch_cnt;
            end
        end

        if (capture) begin
            idx          = IW'(32'(cap_c) * W + (W - 1) - 32'(cap_b));
            buf_nxt[idx] = serial_data;
            if (cap_c == CW'(N_CH - 1) && cap_b == BW'(W - 1)) begin
                data_nxt  = buf_nxt;
                fv_nxt    = 1'b1;
                bit_nxt   = '0;
                ch_nxt    = '0;
                state_nxt = IDLE;
            end else if (cap_b == BW'(W - 1)) begin
                bit_nxt   = '0;
                ch_nxt    = cap_c + CW'(1);
                state_nxt = RECV;
            end else begin
                bit_nxt   = cap_b + BW'(1);
                ch_nxt    = cap_c;
                state_nxt = RECV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            ch_cnt      <= '0;
            asm_buf     <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_nxt;
            ch_cnt      <= ch_nxt;
            asm_buf     <= buf_nxt;
            ch_data     <= data_nxt;
            frame_valid <= fv_nxt;
            frame_err   <= fe_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_deserializer.sv
// Directed bench for tdm_deserializer (N_CH=4, W=8): framing, gaps, abort,
// back-to-back frames and mid-frame reset.
module tb_tdm_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        serial_valid;
    logic        serial_data;
    logic        frame_start;
    logic [31:0] ch_data;
    logic        frame_valid;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int fv_last = 0;
    int fv_prev = 0;

    tdm_deserializer #(.N_CH(4), .W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_valid (serial_valid),
        .serial_data  (serial_data),
        .frame_start  (frame_start),
        .ch_data      (ch_data),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor: counts high cycles of each flag, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_prev = fv_last;
            fv_last = cyc;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (frame_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serial_valid = 1'b0;
            frame_start  = 1'b0;
            @(posedge clk);
        end
    endtask

    // Sends frame bits [from..to] (bit 0 = channel 0 MSB, frame_start on bit 0),
    // with 0..gapmax idle cycles before each beat and random frame_start in gaps.
    task automatic send_bits(input logic [31:0] word, input int from, input int to,
                             input int gapmax);
        int gap;
        for (int i = from; i <= to; i++) begin
            gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                serial_valid = 1'b0;
                frame_start  = 1'($urandom_range(1, 0));
                serial_data  = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            serial_valid = 1'b1;
            frame_start  = (i == 0);
            serial_data  = word[(i / 8) * 8 + 7 - (i % 8)];
            @(posedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_valid = 1'($urandom_range(1, 0));
            frame_start  = 1'($urandom_range(1, 0));
            serial_data  = 1'($urandom_range(1, 0));
            @(posedge clk);
            @(negedge clk);
        end
        rst_n        = 1'b1;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        serial_data  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (ch_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_ch_data: got %h expected %h", ch_data, 32'h0);
        end
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid);
        end
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
    endtask

    task automatic test_basic();
        int fv0, fe0;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_bits(32'h01FF3CA5, 0, 30, 0);
        #1;
        n_cmp++;
        if (ch_data !== 32'h0 || frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_partial: ch_data %h fv %b expected 00000000 0", ch_data, frame_valid);
        end
        send_bits(32'h01FF3CA5, 31, 31, 0);
        #1;
        n_cmp++;
        if (frame_valid !== 1'b1) begin
            n_bad++; $display("FAIL basic_fv_pulse: got %b expected 1", frame_valid);
        end
        n_cmp++;
        if (ch_data !== 32'h01FF3CA5) begin
            n_bad++; $display("FAIL basic_ch_data: got %h expected 01ff3ca5", ch_data);
        end
        idle(1);
        #1;
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_fv_drop: got %b expected 0", frame_valid);
        end
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0) begin
            n_bad++; $display("FAIL basic_pulse_count: fv %0d fe %0d expected 1 0", fv_cnt - fv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_gaps();
        int fv0, fe0;
        do_reset();
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_bits(32'h01FF3CA5, 0, 31, 3);
        idle(2);
        n_cmp++;
        if (ch_data !== 32'h01FF3CA5) begin
            n_bad++; $display("FAIL gaps_ch_data: got %h expected 01ff3ca5", ch_data);
        end
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 0) begin
            n_bad++; $display("FAIL gaps_pulse_count: fv %0d fe %0d expected 1 0", fv_cnt - fv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_abort();
        int fv0, fe0;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_bits(32'hDEADBEEF, 0, 9, 0);
        send_bits(32'h44332211, 0, 0, 0);
        #1;
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_bad++; $display("FAIL abort_err_pulse: got %b expected 1", frame_err);
        end
        n_cmp++;
        if (ch_data !== 32'h01FF3CA5) begin
            n_bad++; $display("FAIL abort_ch_hold: got %h expected 01ff3ca5", ch_data);
        end
        send_bits(32'h44332211, 1, 30, 0);
        #1;
        n_cmp++;
        if (ch_data !== 32'h01FF3CA5 || frame_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_partial: ch_data %h fv %b expected 01ff3ca5 0", ch_data, frame_valid);
        end
        send_bits(32'h44332211, 31, 31, 0);
        #1;
        n_cmp++;
        if (ch_data !== 32'h44332211 || frame_valid !== 1'b1) begin
            n_bad++; $display("FAIL abort_new_frame: ch_data %h fv %b expected 44332211 1", ch_data, frame_valid);
        end
        idle(1);
        n_cmp++;
        if (fv_cnt - fv0 !== 1 || fe_cnt - fe0 !== 1) begin
            n_bad++; $display("FAIL abort_pulse_count: fv %0d fe %0d expected 1 1", fv_cnt - fv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_back_to_back();
        int fv0, fe0;
        fv0 = fv_cnt; fe0 = fe_cnt;
        // Stray beats while idle must be ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            serial_valid = 1'b1;
            frame_start  = 1'b0;
            serial_data  = 1'($urandom_range(1, 0));
            @(posedge clk);
        end
        send_bits(32'h0A0B0C0D, 0, 31, 0);
        #1;
        n_cmp++;
        if (ch_data !== 32'h0A0B0C0D || frame_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first: ch_data %h fv %b expected 0a0b0c0d 1", ch_data, frame_valid);
        end
        send_bits(32'h12345678, 0, 31, 0);
        #1;
        n_cmp++;
        if (ch_data !== 32'h12345678 || frame_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second: ch_data %h fv %b expected 12345678 1", ch_data, frame_valid);
        end
        idle(1);
        n_cmp++;
        if (fv_last - fv_prev !== 32) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d cycles expected 32", fv_last - fv_prev);
        end
        n_cmp++;
        if (fv_cnt - fv0 !== 2 || fe_cnt - fe0 !== 0) begin
            n_bad++; $display("FAIL b2b_pulse_count: fv %0d fe %0d expected 2 0", fv_cnt - fv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_reset_midframe();
        int fv0, fe0;
        send_bits(32'hCAFEF00D, 0, 18, 0);
        @(negedge clk);
        rst_n        = 1'b0;
        serial_valid = 1'b1;
        frame_start  = 1'b0;
        serial_data  = 1'b1;
        @(posedge clk);
        #1;
        fv0 = fv_cnt; fe0 = fe_cnt;
        n_cmp++;
        if (ch_data !== 32'h0) begin
            n_bad++; $display("FAIL midreset_clear: got %h expected 00000000", ch_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            serial_valid = 1'b1;
            frame_start  = 1'b0;
            serial_data  = 1'($urandom_range(1, 0));
            @(posedge clk);
            @(negedge clk);
        end
        serial_valid = 1'b0;
        idle(2);
        n_cmp++;
        if (ch_data !== 32'h0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL midreset_outputs: ch_data %h fv %b fe %b expected 00000000 0 0", ch_data, frame_valid, frame_err);
        end
        n_cmp++;
        if (fv_cnt - fv0 !== 0 || fe_cnt - fe0 !== 0) begin
            n_bad++; $display("FAIL midreset_pulse_count: fv %0d fe %0d expected 0 0", fv_cnt - fv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++; $display("FAIL fv_fe_exclusive: %0d overlapping cycles expected 0", both_cnt);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        serial_valid = 1'b0;
        serial_data  = 1'b0;
        frame_start  = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_deserializer.md
# tdm_deserializer

Receive end of the single-wire time-division-multiplexed link whose transmit side multiplexes channel bits onto one wire by select. Collects a framed serial bit stream, demultiplexes it into `N_CH` parallel channel words of `W` bits, and presents a full frame with a one-cycle valid pulse. Sits between the serial link input and per-channel consumers. Flags framing violations.

## Interface
- `N_CH`, default 4: channels per frame, ≥ 1.
- `W`, default 8: bits per channel word, ≥ 1.

- `clk`  input  1  clock; all logic on rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `serial_valid`  input  1  `serial_data` carries a bit this cycle.
- `serial_data`  input  1  serial bit, channel-word MSB first.
- `frame_start`  input  1  marks the first bit of a frame; meaningful only with `serial_valid`=1.
- `ch_data`  output  `N_CH*W`  last complete frame; channel k in `[k*W +: W]`.
- `frame_valid`  output  1  one-cycle pulse: `ch_data` just updated with a new frame.
- `frame_err`  output  1  one-cycle pulse: partial frame aborted by early `frame_start`.

## Operation
- Bit order: channel 0 first, channels ascending; within a channel, MSB first.
- Internal: state {IDLE, RECV}, bit counter 0..W-1, channel counter 0..N_CH-1, shift/assembly buffer of `N_CH*W` bits separate from `ch_data`.
- "Beat" = cycle with `serial_valid`=1. Cycles with `serial_valid`=0 change nothing; counters and buffer hold, gaps of any length allowed.
- IDLE:
  - beat with `frame_start`=1: capture bit as channel 0 MSB, counters advance, go RECV. If N_CH*W=1, frame completes on this beat.
  - beat with `frame_start`=0: bit discarded, no error, stay IDLE.
- RECV:
  - beat with `frame_start`=0: capture bit at current position, advance bit counter; wrap bit counter W-1→0 and increment channel counter.
  - beat capturing channel N_CH-1, bit 0 (the last bit): frame complete; copy assembled frame to `ch_data`, pulse `frame_valid`, counters to 0, go IDLE.
  - beat with `frame_start`=1: discard partial frame, pulse `frame_err`, capture bit as channel 0 MSB of a new frame, counters restart, stay RECV. `ch_data` unchanged.
- `frame_start` with `serial_valid`=0: ignored in all states.
- `ch_data` holds the last complete frame until the next completes; never shows partial data.
- `frame_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, counters 0, buffer 0, `ch_data`=0, `frame_valid`=0, `frame_err`=0. Reset mid-frame drops the partial frame with no `frame_err`.
- Latency: last bit sampled at edge k, then `ch_data` new and `frame_valid`=1 during cycle after edge k; `frame_valid` low after edge k+1 unless another frame completes.
- `frame_err` is high during the cycle after the edge sampling the offending `frame_start` beat, for exactly one cycle.
- Back-to-back: `frame_start` beat in the cycle right after the last bit is accepted (state already IDLE), no bubble required. Minimum frame period N_CH*W cycles.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with random inputs → `ch_data`=0, `frame_valid`=0, `frame_err`=0.
- N_CH=4, W=8, contiguous 32 beats of bytes 0xA5,0x3C,0xFF,0x01 with `frame_start` on beat 1 → `ch_data`=0x01FF3CA5, single `frame_valid` pulse in cycle after beat 32.
- Same frame with random 0–3-cycle `serial_valid` gaps and toggling `frame_start` during gaps → identical `ch_data`, one pulse, no `frame_err`.
- Abort: `frame_start` again on beat 11, then full frame 0x11,0x22,0x33,0x44 → `frame_err` pulse after beat 11, `ch_data` keeps old value until completion, then 0x44332211 with one `frame_valid`.
- Two back-to-back frames with no idle cycle → `frame_valid` pulses exactly 32 cycles apart, `ch_data` matches each frame in turn. Beats before any `frame_start` are ignored.
- `rst_n` low for one cycle at beat 20, then 12 beats without `frame_start` → outputs 0, no `frame_valid` and no `frame_err`.
